// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo: 8N1 serial receiver with mid-bit sampling feeding a first-word-fall-through byte FIFO
module rs232_rx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          RxD,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          frame_err,
   output logic                          overrun
);
   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
   state_t          state_q, state_d;
   logic            s1_q, s2_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      sh_q, sh_d;
   logic            push, ferr_d, tick;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [AW:0]     count_q;
   logic            frame_err_q, overrun_q;
   logic            full, pop, wr;
   // The start bit is checked half a bit in; every later sample lands one full bit after the previous one
   assign tick = cnt_q == (state_q == START ? CW'(H - 1) : CW'(CLKS_PER_BIT - 1));
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      push    = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         IDLE:    state_d = s2_q ? IDLE : START;
         START:   if (tick) state_d = s2_q ? IDLE : DATA;
         DATA: if (tick) begin
            sh_d    = {s2_q, sh_q[7:1]};
            bit_d   = bit_q + 3'd1;
            state_d = (bit_q == 3'd7) ? STOP : DATA;
         end
         STOP: if (tick) begin
            push    = s2_q;
            ferr_d  = !s2_q;
            state_d = s2_q ? IDLE : WAIT_HI;
         end
         WAIT_HI: state_d = s2_q ? IDLE : WAIT_HI;
         default: state_d = IDLE;
      endcase
      cnt_d = (tick || state_d != state_q) ? '0 : cnt_q + 1'b1;
   end
   assign pop      = rx_valid && rx_ready;
   assign full     = count_q == (AW + 1)'(FIFO_DEPTH);
   assign wr       = push && (!full || pop);
   assign rx_valid = count_q != '0;
   assign rx_data  = rx_valid ? mem_q[rptr_q] : 8'h00;
   assign rx_count = count_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q        <= 1'b1;
         s2_q        <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         sh_q        <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         s1_q        <= RxD;
         s2_q        <= s1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         sh_q        <= sh_d;
         wptr_q      <= wptr_q + AW'(wr);
         rptr_q      <= rptr_q + AW'(pop);
         count_q     <= count_q + (AW + 1)'(wr) - (AW + 1)'(pop);
         frame_err_q <= ferr_d;
         overrun_q   <= push && full && !pop;
      end
   end
   // When full with a pop, the write slot is the head being consumed on this same edge
   always_ff @(posedge clk) begin
      if (wr) mem_q[wptr_q] <= sh_q;
   end
endmodule

// File: tb/tb_rs232_rx_fifo.sv
// tb_rs232_rx_fifo: directed frames with a scoreboard queue checked by a pop monitor
`timescale 1ns/1ps
module tb_rs232_rx_fifo;
   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   logic       clk = 1'b0, rst = 1'b1, RxD = 1'b1, rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun;
   logic [2:0] rx_count;
   int         checks = 0, failures = 0;
   int         cyc = 0, start_cyc = 0, rise_cyc = -1, ferr_n = 0, ovr_n = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] exp_q [$];

   rs232_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .RxD(RxD), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .rx_count(rx_count), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_valid;
      if (frame_err) ferr_n++;
      if (overrun) ovr_n++;
      if (rx_valid && rx_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected: got 0x%0h expected no byte", rx_data);
         end else check("pop_data", int'(rx_data), int'(exp_q.pop_front()));
      end
   end

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic stop, input int ncyc, input int pop_at);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int j = 0; j < ncyc; j++) begin
         @(posedge clk);
         #1;
         if (j == 0) start_cyc = cyc;
         RxD = f[j / CPB];
         if (pop_at >= 0) rx_ready = (j == pop_at);
      end
   endtask

   task automatic drain();
      int n = 0;
      @(posedge clk);
      #1;
      rx_ready = 1'b1;
      while (rx_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_empty", int'(rx_valid), 0);
      rx_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, int'(rx_valid), 0);
      check({tag, "_count"}, int'(rx_count), 0);
      check({tag, "_ferr"}, int'(frame_err), 0);
      check({tag, "_ovr"}, int'(overrun), 0);
      check({tag, "_data"}, int'(rx_data), 0);
   endtask

   initial begin
      tick_n(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick_n(5);
      // single byte at exact baud
      exp_q.push_back(8'hA5);
      send(8'hA5, 1'b1, 10 * CPB, -1);
      check("single_latency", rise_cyc - start_cyc, CPB / 2 + 9 * CPB + 3);
      check("single_data", int'(rx_data), 'hA5);
      check("single_count", int'(rx_count), 1);
      drain();
      check("single_count_after_pop", int'(rx_count), 0);
      check("single_no_ferr", ferr_n, 0);
      check("single_no_ovr", ovr_n, 0);
      // glitch shorter than half a bit
      @(posedge clk);
      #1;
      RxD = 1'b0;
      tick_n(4);
      RxD = 1'b1;
      tick_n(30);
      check("glitch_count", int'(rx_count), 0);
      exp_q.push_back(8'h3C);
      send(8'h3C, 1'b1, 10 * CPB, -1);
      tick_n(2);
      check("glitch_next_count", int'(rx_count), 1);
      drain();
      // framing error with line held low past the stop bit
      send(8'h55, 1'b0, 10 * CPB, -1);
      tick_n(40);
      RxD = 1'b1;
      tick_n(20);
      check("ferr_pulses", ferr_n, 1);
      check("ferr_count", int'(rx_count), 0);
      exp_q.push_back(8'h81);
      send(8'h81, 1'b1, 10 * CPB, -1);
      tick_n(2);
      check("ferr_next_count", int'(rx_count), 1);
      drain();
      // overrun on fifth byte into a depth-4 FIFO
      for (int b = 1; b <= 5; b++) begin
         if (b <= 4) exp_q.push_back(8'(b));
         send(8'(b), 1'b1, 10 * CPB, -1);
      end
      tick_n(2);
      check("ovr_pulses", ovr_n, 1);
      check("ovr_count", int'(rx_count), 4);
      drain();
      // full FIFO with a pop on the fifth byte's stop-sample edge
      for (int b = 1; b <= 5; b++) begin
         exp_q.push_back(8'(b));
         send(8'(b), 1'b1, 10 * CPB, (b == 5) ? CPB / 2 + 9 * CPB + 2 : -1);
      end
      tick_n(2);
      check("fullpop_no_ovr", ovr_n, 1);
      check("fullpop_count", int'(rx_count), 4);
      drain();
      // reset in the middle of bit 4 with two bytes queued
      send(8'h11, 1'b1, 10 * CPB, -1);
      send(8'h22, 1'b1, 10 * CPB, -1);
      send(8'hF0, 1'b1, 5 * CPB + CPB / 2, -1);
      check("pre_reset_count", int'(rx_count), 2);
      rst = 1'b1;
      RxD = 1'b1;
      tick_n(2);
      rst = 1'b0;
      tick_n(1);
      check_reset_outputs("midreset");
      tick_n(20);
      check("midreset_idle_count", int'(rx_count), 0);
      exp_q.push_back(8'h0F);
      send(8'h0F, 1'b1, 10 * CPB, -1);
      tick_n(2);
      check("midreset_next_count", int'(rx_count), 1);
      drain();
      check("scoreboard_empty", exp_q.size(), 0);
      check("total_ferr", ferr_n, 1);
      check("total_ovr", ovr_n, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rs232_rx_fifo.md
# rs232_rx_fifo

RS232 receive path for the BEE3/ML505 test designs: the counterpart of the controller's TxD transmitter. It accepts the asynchronous RxD pin and recovers 8N1 bytes by mid-bit sampling. It buffers the bytes in a first-word-fall-through FIFO for the memory-test command logic. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); legal ≥ 8.
- FIFO_DEPTH, 16, byte entries; power of two, ≥ 2.
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- RxD  input  1  asynchronous serial line, idle high.
- rx_data  output  8  FIFO head byte; valid only while rx_valid.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer pops head when rx_valid && rx_ready.
- rx_count  output  $clog2(FIFO_DEPTH)+1  bytes stored.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped, FIFO full.

## Operation
- Synchronizer: two flops on RxD, both reset to 1; rxd_s = RxD delayed 2 clk. All decisions use rxd_s.
- H = CLKS_PER_BIT/2 (integer division). The bit counter (0..CLKS_PER_BIT-1) is cleared on every state entry.
- FSM states:
  - IDLE: if rxd_s==0, go to START.
  - START: after H cycles, sample rxd_s. If 0, go to DATA. If 1, the start was false; go to IDLE with no flag.
  - DATA: every CLKS_PER_BIT cycles, sample one bit into a shift register, LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxd_s.
    - If 1: push the byte, then go to IDLE.
    - If 0: pulse frame_err, discard the byte, and go to WAIT_HI.
  - WAIT_HI: stay until rxd_s==1 (break/line-low condition), then go to IDLE.
- Push when full: the byte is discarded and overrun pulses, unless a pop occurs in the same cycle. In that case the push is accepted and rx_count is unchanged.
- Pop when empty: ignored.
- Simultaneous push and pop on a non-empty FIFO: both happen, and rx_count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. rx_count is computed from a registered counter, not from pointer subtraction.
- Reset mid-frame: FSM returns to IDLE, the FIFO is emptied, and the partial byte is lost. A line that is still low after reset is treated as a new start bit.

## Timing
- Reset values: rx_valid=0, rx_count=0, frame_err=0, overrun=0, rx_data=0x00, FSM=IDLE, synchronizer flops=1.
- Let T0 be the first edge at which the FSM sees rxd_s==0 in IDLE.
  - Start sample: T0+H.
  - Data bit i sample: T0+H+(i+1)·CLKS_PER_BIT.
  - Stop sample: T0+H+9·CLKS_PER_BIT.
- Push happens on the stop-sample edge. rx_valid/rx_data are updated in the following cycle (1-cycle registered write latency into FWFT output).
- frame_err/overrun assert in the cycle after the stop sample, for exactly 1 cycle.
- Pop: when rx_valid && rx_ready at edge N, the next byte (or rx_valid=0) is visible after edge N. Back-to-back pops at 1 byte/cycle are supported.
- Earliest next start detection after a good stop sample: the next cycle. This supports back-to-back frames with one stop bit.
- RxD-to-rxd_s latency: 2 cycles. Tolerance: ±(H-2) cycles of bit-edge drift over a frame.

## Test plan
- Single byte: CLKS_PER_BIT=16, send 0xA5 at an exact baud rate.
  - Expect rx_valid=1 with rx_data=0xA5 at T0+H+9·16+1 and rx_count=1.
  - Pop: rx_valid=0, rx_count=0.
  - No error pulses.
- Glitch: drive RxD low for 4 cycles, then high.
  - FSM returns to IDLE and no byte is pushed.
  - A following 0x3C is received correctly.
- Framing error: send 0x55 with stop bit low, held low for 40 cycles.
  - Expect a 1-cycle frame_err and rx_count=0.
  - No start is detected until RxD returns high.
  - A next byte 0x81 is received correctly.
- Overrun: FIFO_DEPTH=4, rx_ready=0, send 0x01..0x05 back-to-back.
  - Expect rx_count=4 and one overrun pulse on the 5th byte.
  - Pops return 0x01, 0x02, 0x03, 0x04 in order.
- Full with simultaneous pop: with FIFO full, assert rx_ready exactly at the 5th byte's stop-sample edge.
  - No overrun; rx_count stays 4.
  - Drain order is 0x02, 0x03, 0x04, 0x05.
- Reset mid-frame: assert rst during DATA bit 4 of 0xF0, with 2 bytes already queued.
  - After reset, all outputs are at reset values.
  - With RxD held high, the next frame 0x0F is received alone (rx_count=1).
